// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with KMP next-state table and saturating match count
//
// Ports:
//   clk      clock; all state updates on the falling edge
//   reset    asynchronous active-low reset
//   i        serial data bit (first bit received = PATTERN MSB)
//   i_valid  qualifies i; state and count hold when low
//   ovl      1 = overlapped matching, 0 = restart from idle after a match
//   clear    synchronous clear of match history and counter (beats a match)
//   y        registered one-cycle match pulse
//   busy     registered (state != 0), i.e. a partial match is in progress
//   count    saturating number of matches since reset/clear

module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i,
    input  logic             i_valid,
    input  logic             ovl,
    input  logic             clear,
    output logic             y,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    // State must be able to express PAT_LEN as a transition target (match).
    localparam int SW  = $clog2(PAT_LEN + 1);
    localparam int TBL = 1 << SW;

    // Bit k of the pattern in arrival order (k = 0 is the first bit received).
    function automatic logic pat_bit(input int k);
        logic [PAT_LEN-1:0] sh;
        sh = PATTERN >> (PAT_LEN - 1 - k);
        return sh[0];
    endfunction

    // KMP failure function: longest proper border of the length-len prefix.
    function automatic int fail_of(input int len);
        int f [17];
        int j;
        for (int k = 0; k < 17; k++) f[k] = 0;
        for (int k = 2; k <= len; k++) begin
            j = f[k-1];
            while (j > 0 && pat_bit(j) != pat_bit(k-1)) j = f[j];
            if (pat_bit(j) == pat_bit(k-1)) j++;
            f[k] = j;
        end
        return f[len];
    endfunction

    // Transition from matched-prefix length s on bit b; PAT_LEN means a match.
    function automatic int kmp_next(input int s, input logic b);
        int j;
        if (s >= PAT_LEN) return 0;
        j = s;
        while (j > 0 && pat_bit(j) != b) j = fail_of(j);
        if (pat_bit(j) == b) j++;
        return j;
    endfunction

    localparam int BORDER = fail_of(PAT_LEN);

    // Next-state table folded from the failure chain at elaboration, so the
    // datapath is a single table lookup per valid bit. Unreachable state
    // codes fall back to idle.
    logic [SW-1:0] nxt_tbl [TBL][2];

    for (genvar s = 0; s < TBL; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NXT = kmp_next(s, b == 1);
            assign nxt_tbl[s][b] = SW'(NXT);
        end
    end

    logic [SW-1:0] state;
    logic [SW-1:0] raw;
    logic [SW-1:0] nstate;
    logic          hit;

    always_comb begin
        raw    = nxt_tbl[state][i];
        hit    = (raw == SW'(PAT_LEN));
        nstate = raw;
        // ovl sampled with the completing bit picks the restart point only.
        if (hit) nstate = ovl ? SW'(BORDER) : '0;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
            busy  <= 1'b0;
            y     <= 1'b0;
            count <= '0;
        end else if (clear) begin
            state <= '0;
            busy  <= 1'b0;
            y     <= 1'b0;
            count <= '0;
        end else if (i_valid) begin
            state <= nstate;
            busy  <= (nstate != '0);
            y     <= hit;
            if (hit && count != '1) count <= count + CNT_W'(1);
        end else begin
            y <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param (default and 2-bit counter instances)

module tb_seq_detect_param;

    localparam int          PL  = 4;
    localparam logic [PL-1:0] PAT = 4'b1001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i = 1'b0;
    logic       i_valid = 1'b0;
    logic       ovl = 1'b0;
    logic       clear = 1'b0;
    logic       y0, busy0, y1, busy1;
    logic [7:0] count0;
    logic [1:0] count1;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .i(i), .i_valid(i_valid), .ovl(ovl), .clear(clear),
        .y(y0), .busy(busy0), .count(count0)
    );

    seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .i(i), .i_valid(i_valid), .ovl(ovl), .clear(clear),
        .y(y1), .busy(busy1), .count(count1)
    );

    typedef struct packed {
        logic       y;
        logic       busy;
        logic [7:0] c0;
        logic [1:0] c1;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    // Reference model: valid bits since the last restart (only the newest PL kept).
    bit   hist[$];
    int   m_c0 = 0;
    int   m_c1 = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit pbit(input int k);
        logic [PL-1:0] s;
        s = PAT >> (PL - 1 - k);
        return s[0];
    endfunction

    // Longest pattern prefix (shorter than PL) that ends the history.
    function automatic int model_state();
        int n;
        bit ok;
        n = hist.size();
        for (int k = PL - 1; k >= 1; k--) begin
            if (n >= k) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (hist[n-k+j] != pbit(j)) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    function automatic bit model_match();
        if (hist.size() != PL) return 1'b0;
        for (int j = 0; j < PL; j++)
            if (hist[j] != pbit(j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input bit b, input bit o);
        exp_t e;
        bit   ey;
        @(posedge clk);
        reset   = r;
        clear   = c;
        i_valid = v;
        i       = b;
        ovl     = o;
        ey = 1'b0;
        if (!r || c) begin
            hist.delete();
            m_c0 = 0;
            m_c1 = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > PL) void'(hist.pop_front());
            ey = model_match();
            if (ey) begin
                if (m_c0 < 255) m_c0++;
                if (m_c1 < 3) m_c1++;
                if (!o) hist.delete();
            end
        end
        e.y    = ey;
        e.busy = (model_state() != 0);
        e.c0   = 8'(m_c0);
        e.c1   = 2'(m_c1);
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit o);
        for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b0, 1'b1, bits[k], o);
    endtask

    task automatic drain();
        @(negedge clk);
        #2;
    endtask

    // Monitor: outputs are presented every falling edge; compare each one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y0", y0, e.y);
                chk("busy0", busy0, e.busy);
                chk("count0", count0, e.c0);
                chk("y1", y1, e.y);
                chk("busy1", busy1, e.busy);
                chk("count1", count1, e.c1);
                if (y0) pulses++;
            end
        end
    end

    initial begin
        int p;
        bit o;

        // Reset held low, then released idle.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // T1: overlapped 1001001 -> two pulses
        drain(); p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'b1001001, 7, 1'b1);
        drain();
        chk("t1_pulses", pulses - p, 2);
        chk("t1_count", count0, 2);

        // T2: non-overlapped -> bit 4 is not reused
        p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'b1001001, 7, 1'b0);
        drain();
        chk("t2_pulses", pulses - p, 1);
        chk("t2_count", count0, 1);

        // T3: invalid gaps are ignored
        p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'b10, 2, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        send(32'b01, 2, 1'b1);
        drain();
        chk("t3_pulses", pulses - p, 1);
        chk("t3_count", count0, 1);

        // T4: reset mid-pattern restarts from idle
        p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'b100, 3, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();
        chk("t4_pulses", pulses - p, 0);
        chk("t4_count", count0, 0);
        chk("t4_busy", busy0, 1);

        // T5: (1001)x5 overlapped, 2-bit counter saturates at 3
        p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'h99999, 20, 1'b1);
        drain();
        chk("t5_pulses", pulses - p, 5);
        chk("t5_count0", count0, 5);
        chk("t5_count1", count1, 3);

        // T6: clear beats the completing bit; following 001 gives no pulse
        p = pulses;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'b100, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send(32'b001, 3, 1'b1);
        drain();
        chk("t6_pulses", pulses - p, 0);
        chk("t6_count", count0, 0);
        chk("t6_busy", busy0, 1);

        // Saturation of the 8-bit counter with a long overlapped run.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 1100; k++) step(1'b1, 1'b0, 1'b1, pbit(k % PL), 1'b1);
        drain();
        chk("sat_count0", count0, 255);
        chk("sat_count1", count1, 3);

        // Randomised segments; ovl fixed within a segment.
        for (int seg = 0; seg < 8; seg++) begin
            o = 1'($urandom_range(0, 1));
            step(1'b1, 1'b1, 1'b0, 1'b0, o);
            for (int k = 0; k < 300; k++)
                step(1'($urandom_range(0, 99) != 0),
                     1'($urandom_range(0, 49) == 0),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     o);
        end

        drain();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
